// File: rtl/synaptic_current_integrator.sv
// Synaptic current integrator: on each tick, decays the held current and then adds the
// weight of every spiking presynaptic line, one synapse per cycle, with saturating arithmetic.
module synaptic_current_integrator #(
   parameter int N  = 32,
   parameter int Q  = 16,
   parameter int M  = 8,
   parameter int AW = (M > 1) ? $clog2(M) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic [M-1:0]  spikes,
   input  logic [N-1:0]  decay,
   input  logic          w_we,
   input  logic [AW-1:0] w_addr,
   input  logic [N-1:0]  w_data,
   output logic [N-1:0]  i_out,
   output logic          i_valid,
   output logic          busy,
   output logic          overrun
);

   typedef enum logic [1:0] {IDLE, DECAY, ACCUM, DONE} state_t;

   state_t              state_q, state_d;
   logic [M-1:0]        snap_q, snap_d;
   logic [N-1:0]        kreg_q, kreg_d;
   logic [N-1:0]        acc_q, acc_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic [N-1:0]        i_out_q, i_out_d;
   logic                i_valid_q, i_valid_d;
   logic                busy_q, busy_d;
   logic                overrun_q, overrun_d;
   logic [N-1:0]        weight_q [M];
   logic [N-1:0]        weight_d [M];

   logic signed [2*N-1:0] prod;
   logic [N-1:0]          dec_term;

   // Clamp an (N+1)-bit two's complement sum/difference back into N bits.
   function automatic logic [N-1:0] sat(input logic [N:0] s);
      if (s[N] != s[N-1])
         return s[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      return s[N-1:0];
   endfunction

   assign prod     = $signed({{N{i_out_q[N-1]}}, i_out_q} * {{N{kreg_q[N-1]}}, kreg_q});
   assign dec_term = N'(prod >>> Q);

   // NOTE: combinational blocks use blocking '=' and give every output a default first,
   // so no path through the block can leave a value held and infer a latch.
   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      kreg_d    = kreg_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      i_out_d   = i_out_q;
      i_valid_d = 1'b0;
      busy_d    = busy_q;
      overrun_d = overrun_q | (tick & (state_q != IDLE));
      weight_d  = weight_q;

      // A write colliding with the synapse being accumulated lands after this cycle's read.
      if (w_we && (int'(w_addr) < M))
         weight_d[w_addr] = w_data;

      case (state_q)
         IDLE: begin
            if (tick) begin
               snap_d  = spikes;
               kreg_d  = decay;
               busy_d  = 1'b1;
               state_d = DECAY;
            end
         end
         DECAY: begin
            acc_d   = sat({i_out_q[N-1], i_out_q} - {dec_term[N-1], dec_term});
            idx_d   = '0;
            state_d = ACCUM;
         end
         ACCUM: begin
            if (snap_q[idx_q])
               acc_d = sat({acc_q[N-1], acc_q} + {weight_q[idx_q][N-1], weight_q[idx_q]});
            if (idx_q == AW'(M - 1)) begin
               // Publish on entry to DONE so i_out and i_valid are both visible in DONE.
               i_out_d   = acc_d;
               i_valid_d = 1'b1;
               state_d   = DONE;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         snap_q    <= '0;
         kreg_q    <= '0;
         acc_q     <= '0;
         idx_q     <= '0;
         i_out_q   <= '0;
         i_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         // NOTE: the weight table is reset deliberately; a freshly reset integrator must
         // contribute zero current, so this stays flops rather than a RAM macro.
         for (int k = 0; k < M; k++) weight_q[k] <= '0;
      end else begin
         state_q   <= state_d;
         snap_q    <= snap_d;
         kreg_q    <= kreg_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         i_out_q   <= i_out_d;
         i_valid_q <= i_valid_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
         for (int k = 0; k < M; k++) weight_q[k] <= weight_d[k];
      end
   end

   assign i_out   = i_out_q;
   assign i_valid = i_valid_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule
